// File: rtl/controller_if.sv
// controller_if: instruction fields and PSR flags into the controller; datapath selects, enables and STATE out of it
interface controller_if #(
    parameter int PSRL = 5
);
    logic [3:0]      OP_CODE;
    logic [3:0]      OP_EXT;
    logic [3:0]      Rdest_addr;
    logic [PSRL-1:0] PSR_OUT;
    logic            PC_S;
    logic            MEM_DATA_S;
    logic [1:0]      MEM_S;
    logic [1:0]      WD_S;
    logic [1:0]      ALUA_S;
    logic [1:0]      ALUB_S;
    logic            INSTR_EN;
    logic            ALU_OUT_EN;
    logic            MEM_REG_EN;
    logic            PC_EN;
    logic            PSR_EN;
    logic            SE_SIGN;
    logic            REG_WR;
    logic            MEM_WE;
    logic [3:0]      STATE;
    modport master (
        input  OP_CODE, OP_EXT, Rdest_addr, PSR_OUT,
        output PC_S, MEM_DATA_S, MEM_S, WD_S, ALUA_S, ALUB_S,
               INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN,
               SE_SIGN, REG_WR, MEM_WE, STATE
    );
    modport slave (
        output OP_CODE, OP_EXT, Rdest_addr, PSR_OUT,
        input  PC_S, MEM_DATA_S, MEM_S, WD_S, ALUA_S, ALUB_S,
               INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN,
               SE_SIGN, REG_WR, MEM_WE, STATE
    );
endinterface

// File: rtl/controller.sv
// controller: multi-cycle Moore control FSM; clk, reset (async active-low), bus = controller_if.master (opcode fields/PSR in, selects/enables/STATE out)
module controller #(
    parameter int PSRL = 5
) (
    input  logic         clk,
    input  logic         reset,
    controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        FWAIT   = 4'd1,
        DECODE  = 4'd2,
        ALU_R   = 4'd3,
        ALU_I   = 4'd4,
        ALU_WB  = 4'd5,
        MOV     = 4'd6,
        MOVI    = 4'd7,
        LD_ADDR = 4'd8,
        LD_WAIT = 4'd9,
        LD_WB   = 4'd10,
        STORE   = 4'd11,
        JUMP    = 4'd12,
        BRANCH  = 4'd13
    } state_t;
    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d, ext_q, ext_d, cond_q, cond_d;
    logic [PSRL-1:0] psr;
    logic            psr_unused;
    logic            taken;
    assign psr        = bus.PSR_OUT;
    assign psr_unused = ^psr;
    assign bus.STATE  = state_q;
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            4'b0000: taken = psr[3];
            4'b0001: taken = !psr[3];
            4'b0100: taken = psr[1];
            4'b0101: taken = !psr[1];
            4'b1100: taken = psr[4];
            4'b1101: taken = !psr[4];
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
    always_comb begin
        state_d        = FETCH;
        op_d           = op_q;
        ext_d          = ext_q;
        cond_d         = cond_q;
        bus.PC_S       = 1'b0;
        bus.MEM_DATA_S = 1'b0;
        bus.MEM_S      = 2'd0;
        bus.WD_S       = 2'd0;
        bus.ALUA_S     = 2'd0;
        bus.ALUB_S     = 2'd0;
        bus.INSTR_EN   = 1'b0;
        bus.ALU_OUT_EN = 1'b0;
        bus.MEM_REG_EN = 1'b0;
        bus.PC_EN      = 1'b0;
        bus.PSR_EN     = 1'b0;
        bus.SE_SIGN    = 1'b0;
        bus.REG_WR     = 1'b0;
        bus.MEM_WE     = 1'b0;
        case (state_q)
            FETCH: begin
                bus.MEM_S = 2'd1;
                state_d   = FWAIT;
            end
            FWAIT: begin
                bus.MEM_S    = 2'd1;
                bus.INSTR_EN = 1'b1;
                bus.PC_EN    = 1'b1;
                bus.PC_S     = 1'b1;
                bus.ALUA_S   = 2'd1;
                bus.ALUB_S   = 2'd2;
                state_d      = DECODE;
            end
            DECODE: begin
                op_d   = bus.OP_CODE;
                ext_d  = bus.OP_EXT;
                cond_d = bus.Rdest_addr;
                case (bus.OP_CODE)
                    4'b0000: state_d = (bus.OP_EXT == 4'b1101) ? MOV : ALU_R;
                    4'b1101: state_d = MOVI;
                    4'b0001, 4'b0010, 4'b0011,
                    4'b0101, 4'b1001, 4'b1011: state_d = ALU_I;
                    4'b0100: state_d = (bus.OP_EXT == 4'b0000) ? LD_ADDR :
                                       (bus.OP_EXT == 4'b0100) ? STORE :
                                       (bus.OP_EXT == 4'b1100) ? JUMP : FETCH;
                    4'b1100: state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            ALU_R: begin
                bus.ALU_OUT_EN = 1'b1;
                bus.PSR_EN     = 1'b1;
                state_d        = (ext_q == 4'b1011) ? FETCH : ALU_WB;
            end
            ALU_I: begin
                bus.ALUA_S     = 2'd2;
                bus.ALU_OUT_EN = 1'b1;
                bus.PSR_EN     = 1'b1;
                bus.SE_SIGN    = op_q inside {4'b0101, 4'b1001, 4'b1011};
                state_d        = (op_q == 4'b1011) ? FETCH : ALU_WB;
            end
            ALU_WB: begin
                bus.WD_S   = 2'd3;
                bus.REG_WR = 1'b1;
            end
            MOV: begin
                bus.WD_S   = 2'd1;
                bus.REG_WR = 1'b1;
            end
            MOVI: bus.REG_WR = 1'b1;
            LD_ADDR: state_d = LD_WAIT;
            LD_WAIT: begin
                bus.MEM_REG_EN = 1'b1;
                state_d        = LD_WB;
            end
            LD_WB: begin
                bus.WD_S   = 2'd2;
                bus.REG_WR = 1'b1;
            end
            STORE: bus.MEM_WE = 1'b1;
            JUMP: bus.PC_EN = taken;
            BRANCH: begin
                bus.ALUA_S  = taken ? 2'd1 : 2'd0;
                bus.ALUB_S  = taken ? 2'd1 : 2'd0;
                bus.SE_SIGN = taken;
                bus.PC_S    = taken;
                bus.PC_EN   = taken;
            end
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            op_q    <= 4'd0;
            ext_q   <= 4'd0;
            cond_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ext_q   <= ext_d;
            cond_q  <= cond_d;
        end
    end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter: PSRL, 5, width of the PSR flag vector.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 OP_CODE  input  4  INSTR[15:12] from the datapath.
REQ-005 OP_EXT  input  4  INSTR[7:4].
REQ-006 Rdest_addr  input  4  INSTR[11:8]; condition code for Bcond/Jcond.
REQ-007 PSR_OUT  input  PSRL  registered flags: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
REQ-008 PC_S, MEM_DATA_S  output  1 each  pc_mux select (0 Rsrc, 1 ALU) and mem_data_mux select (0 Rdest, 1 IMM).
REQ-009 MEM_S  output  2  address select: 0 Rsrc, 1 PC.
REQ-010 WD_S  output  2  write-data select: 0 IMM, 1 Rsrc, 2 MEM reg, 3 ALU_OUT.
REQ-011 ALUA_S  output  2  ALU A select: 0 Rsrc, 1 PC, 2 IMM.
REQ-012 ALUB_S  output  2  ALU B select: 0 Rdest, 1 IMM, 2 one.
REQ-013 INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN  output  1 each  register enables.
REQ-014 SE_SIGN, REG_WR, MEM_WE  output  1 each  sign-extend select, register-file write, memory write.
REQ-015 STATE  output  4  current state code, for debug and verification.

Function
REQ-016 Moore FSM: every output is a function of state plus the latched opcode fields; each output is 0 unless stated otherwise.
REQ-017 State codes: FETCH=0, FWAIT=1, DECODE=2, ALU_R=3, ALU_I=4, ALU_WB=5, MOV=6, MOVI=7, LD_ADDR=8, LD_WAIT=9, LD_WB=10, STORE=11, JUMP=12, BRANCH=13.
REQ-018 FETCH: MEM_S=1; next FWAIT (memory read latency is one cycle).
REQ-019 FWAIT: MEM_S=1, INSTR_EN=1, PC_EN=1, PC_S=1, ALUA_S=1, ALUB_S=2 (PC<=PC+1); next DECODE.
REQ-020 DECODE: no enables asserted; Rsrc/Rdest flops capture; dispatch per REQ-021.
REQ-021 Dispatch:
- OP 0000, EXT 1101 -> MOV; other EXT -> ALU_R.
- OP 1101 -> MOVI.
- OP 0001, 0010, 0011, 0101, 1001, 1011 -> ALU_I.
- OP 0100: EXT 0000 -> LD_ADDR; EXT 0100 -> STORE; EXT 1100 -> JUMP.
- OP 1100 -> BRANCH.
- Anything else -> FETCH (NOP).
REQ-022 ALU_R: ALUA_S=0, ALUB_S=0, ALU_OUT_EN=1, PSR_EN=1; next FETCH if EXT=1011 (CMP), else ALU_WB.
REQ-023 ALU_I: ALUA_S=2, ALUB_S=0, ALU_OUT_EN=1, PSR_EN=1, SE_SIGN=1 for OP 0101/1001/1011 else 0; next FETCH if OP=1011 (CMPI), else ALU_WB.
REQ-024 ALU_WB: WD_S=3, REG_WR=1; next FETCH.
REQ-025 MOV: WD_S=1, REG_WR=1; next FETCH. MOVI: WD_S=0, SE_SIGN=0, REG_WR=1; next FETCH.
REQ-026 Load sequence:
- LD_ADDR: MEM_S=0.
- LD_WAIT: MEM_S=0, MEM_REG_EN=1.
- LD_WB: WD_S=2, REG_WR=1.
- Next FETCH.
REQ-027 STORE: MEM_S=0, MEM_DATA_S=0, MEM_WE=1 for exactly one cycle; next FETCH.
REQ-028 Condition true for Rdest_addr:
- 0000 when Z=1; 0001 when Z=0.
- 0100 when L=1; 0101 when L=0.
- 1100 when N=1; 1101 when N=0.
- 1110 always.
- All other codes false.
REQ-029 JUMP: if true, PC_S=0, PC_EN=1; next FETCH.
REQ-030 BRANCH: if true, ALUA_S=1, ALUB_S=1, SE_SIGN=1, PC_S=1, PC_EN=1 (PC<=PC+1+sext(disp)); next FETCH.
REQ-031 Not-taken JUMP/BRANCH assert no enables.
REQ-032 Conditions use PSR_OUT as held during JUMP/BRANCH, so a CMP immediately preceding is visible.
REQ-033 REG_WR, MEM_WE, PC_EN and PSR_EN are each asserted at most one cycle per instruction, PC_EN excepted in FWAIT.
REQ-034 Unreachable state codes 14/15 go to FETCH on the next clock.

Reset
REQ-035 reset low forces state FETCH asynchronously; outputs then MEM_S=01, all others 0, STATE=0.
REQ-036 reset held low keeps FETCH. Release takes effect at the first rising clk with reset high.
REQ-037 reset asserted mid-instruction aborts it with no further REG_WR/MEM_WE/PC_EN.

Verification
REQ-038 Reset mid-LD_WAIT -> STATE=0 immediately; no REG_WR pulse after release.
REQ-039 OP=0000, EXT=0101 (ADD) -> states 0,1,2,3,5,0; REG_WR=1 only in state 5 with WD_S=3.
REQ-040 OP=0000, EXT=1011 (CMP) -> states 0,1,2,3,0; PSR_EN=1 in state 3; no REG_WR.
REQ-041 OP=0100, EXT=0000 (LOAD) -> states 8,9,10 after DECODE; MEM_REG_EN in 9; WD_S=2, REG_WR in 10. STORE -> MEM_WE=1 for one cycle in state 11.
REQ-042 OP=1100, Rdest_addr=0000: with Z=1 -> PC_EN=1, ALUA_S=1, ALUB_S=1, SE_SIGN=1; with Z=0 -> PC_EN=0; Rdest_addr=1110 always taken; 0010 never taken.
REQ-043 OP=1110 -> states 0,1,2,0 with no writes; MOVI -> WD_S=0, SE_SIGN=0, REG_WR=1.
